// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
//   - default values of the LATENCY / QDEPTH / MEM_WORDS parameters
//   - width of the latency counter (holds up to 15)
//   - FSM state encoding used to service the request queue
package mem_pkg;

  localparam int unsigned LATENCY_DEFAULT   = 4;
  localparam int unsigned QDEPTH_DEFAULT    = 4;
  localparam int unsigned MEM_WORDS_DEFAULT = 1024;
  localparam int unsigned CNT_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a request at the queue head
    ST_WAIT = 2'd1,  // counting down the access latency
    ST_DONE = 2'd2   // completing the head request, popping it
  } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle of the memory responder.
//   master : requester side (drives addr/ren/wen/wdata)
//   slave  : responder side (drives ready/rdata/valid/proto_err)
interface mem_responder_if;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        proto_err;

  modport master (
    input  mem_ready, mem_rdata, mem_valid, proto_err,
    output mem_addr, mem_ren, mem_wen, mem_wdata
  );

  modport slave (
    output mem_ready, mem_rdata, mem_valid, proto_err,
    input  mem_addr, mem_ren, mem_wen, mem_wdata
  );
endinterface

// File: rtl/req_fifo.sv
// Synchronous request FIFO.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data  : write one entry (caller guarantees not full)
//   i_pop           : drop the head entry (caller guarantees not empty)
//   o_data          : head entry
//   o_full, o_empty : occupancy flags, decoded from registered count only
module req_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (i_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({i_push, i_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the
  // pointers/count, and a reset-free array maps onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (i_push) store_q[wr_ptr_q] <= i_data;
  end

  assign o_data  = store_q[rd_ptr_q];
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder.
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   o_mem_ready            : a request can be accepted this cycle (queue not full)
//   i_mem_addr             : byte address, word index taken from [IDX_W+1:2]
//   i_mem_ren / i_mem_wen  : read / full-word write request (exactly one)
//   i_mem_wdata            : write data
//   o_mem_rdata            : read data, zero unless o_mem_valid
//   o_mem_valid            : one-cycle pulse per completed read
//   o_proto_err            : sticky, set by a request with ren and wen both high
// Requests are queued and serviced in order; each one waits LATENCY cycles
// after reaching the head before it completes in the DONE state.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY   = LATENCY_DEFAULT,
  parameter int unsigned QDEPTH    = QDEPTH_DEFAULT,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_mem_ready,
  input  logic [31:0] i_mem_addr,
  input  logic        i_mem_ren,
  input  logic        i_mem_wen,
  input  logic [31:0] i_mem_wdata,
  output logic [31:0] o_mem_rdata,
  output logic        o_mem_valid,
  output logic        o_proto_err
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam int unsigned ENTRY_W = 1 + 32 + IDX_W;  // {is_write, wdata, index}

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             err_q,   err_d;

  logic [31:0]      mem_q [MEM_WORDS];

  logic               fifo_full, fifo_empty, pop;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  logic               head_write;
  logic [31:0]        head_wdata;
  logic [IDX_W-1:0]   head_idx;
  logic               accept, illegal, do_read, do_write;

  // Only the word index is stored; the remaining address bits wrap silently.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_mem_addr[31:IDX_W+2], i_mem_addr[1:0]};

  assign o_mem_ready = !fifo_full;
  assign accept      = o_mem_ready && (i_mem_ren != i_mem_wen);
  assign illegal     = o_mem_ready && i_mem_ren && i_mem_wen;
  assign push_entry  = {i_mem_wen, i_mem_wdata, i_mem_addr[IDX_W+1:2]};

  req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (QDEPTH)
  ) u_req_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (accept),
    .i_data  (push_entry),
    .i_pop   (pop),
    .o_data  (head_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign {head_write, head_wdata, head_idx} = head_entry;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    do_read  = 1'b0;
    do_write = 1'b0;
    err_d    = err_q | illegal;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The cycle that sees zero is the last WAIT cycle, giving
        // LATENCY cycles in WAIT before DONE.
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_DONE: begin
        pop      = 1'b1;
        do_read  = !head_write;
        do_write = head_write;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; reset forces IDLE so no write can fire for a
  // discarded request.
  always_ff @(posedge i_clk) begin
    if (do_write) mem_q[head_idx] <= head_wdata;
  end

  // Outputs decode from registered state, so reset clears them asynchronously.
  assign o_mem_valid = do_read;
  assign o_mem_rdata = do_read ? mem_q[head_idx] : '0;
  assign o_proto_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_mem_responder;

  localparam int unsigned LATENCY   = 4;
  localparam int unsigned QDEPTH    = 4;
  localparam int unsigned MEM_WORDS = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_responder_if mem_if ();

  mem_responder #(
    .LATENCY   (LATENCY),
    .QDEPTH    (QDEPTH),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .o_mem_ready (mem_if.mem_ready),
    .i_mem_addr  (mem_if.mem_addr),
    .i_mem_ren   (mem_if.mem_ren),
    .i_mem_wen   (mem_if.mem_wen),
    .i_mem_wdata (mem_if.mem_wdata),
    .o_mem_rdata (mem_if.mem_rdata),
    .o_mem_valid (mem_if.mem_valid),
    .o_proto_err (mem_if.proto_err)
  );

  // Reference model: each accepted request completes LATENCY+1 edges after
  // it reaches an idle responder; requests are served one at a time, and a
  // request can only start once the previous one has left the queue.
  typedef struct {
    bit          is_write;
    int unsigned idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          known;
    int          done;   // edge that begins the completion cycle
  } req_m_t;

  req_m_t      pend[$];
  logic [31:0] ref_mem [int unsigned];
  int          last_done = -100;
  int          last_acc  = 0;
  bit          exp_err   = 1'b0;
  int          cyc       = 0;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_valid  = 0;
  int          obs_valid_edge = 0;
  logic [31:0] obs_rdata = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pre_val(input int unsigned idx);
    if (idx == 32'h04)      return 32'hCAFE_F00D;
    else if (idx == 32'h20) return 32'h0BAD_BEEF;
    else                    return {16'hC0DE, 16'(idx)};
  endfunction

  // One clock cycle: drive inputs, update the model at the edge, then
  // compare all outputs at the following falling edge.
  task automatic tick(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, output bit acc);
    bit     rdy, found, exp_valid;
    req_m_t r;
    mem_if.mem_ren   = ren;
    mem_if.mem_wen   = wen;
    mem_if.mem_addr  = addr;
    mem_if.mem_wdata = wdata;
    rdy = (pend.size() < QDEPTH);
    @(posedge clk);
    cyc++;
    while (pend.size() > 0 && pend[0].done < cyc) begin
      if (pend[0].is_write) ref_mem[pend[0].idx] = pend[0].wdata;
      void'(pend.pop_front());
    end
    acc = 1'b0;
    if (rdy && ren && wen) begin
      exp_err = 1'b1;
    end else if (rdy && (ren != wen)) begin
      r.is_write = wen;
      r.idx      = (addr >> 2) % MEM_WORDS;
      r.wdata    = wdata;
      r.rdata    = '0;
      r.known    = 1'b0;
      if (!wen) begin
        found = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (!found && pend[i].is_write && pend[i].idx == r.idx) begin
            r.rdata = pend[i].wdata;
            r.known = 1'b1;
            found   = 1'b1;
          end
        end
        if (!found && ref_mem.exists(r.idx)) begin
          r.rdata = ref_mem[r.idx];
          r.known = 1'b1;
        end
      end
      r.done    = ((cyc > last_done + 1) ? cyc : last_done + 1) + LATENCY + 1;
      last_done = r.done;
      last_acc  = cyc;
      pend.push_back(r);
      acc = 1'b1;
    end
    @(negedge clk);
    exp_valid = (pend.size() > 0) && (pend[0].done == cyc) && !pend[0].is_write;
    check("ready", mem_if.mem_ready, pend.size() < QDEPTH);
    check("valid", mem_if.mem_valid, exp_valid);
    check("proto_err", mem_if.proto_err, exp_err);
    if (exp_valid && pend[0].known) check("rdata", mem_if.mem_rdata, pend[0].rdata);
    if (mem_if.mem_valid) begin
      n_valid++;
      obs_valid_edge = cyc;
      obs_rdata      = mem_if.mem_rdata;
    end
  endtask

  task automatic idle();
    bit acc;
    tick(1'b0, 1'b0, '0, '0, acc);
  endtask

  task automatic send(input logic ren, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bit acc = 1'b0;
    int n   = 0;
    while (!acc && n < 64) begin
      tick(ren, wen, addr, wdata, acc);
      n++;
    end
    check("send_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    int n = 0;
    while (pend.size() > 0 && n < 300) begin
      idle();
      n++;
    end
    check("drain_done", pend.size(), 0);
  endtask

  // Called at a falling edge; reset is asserted away from any clock edge.
  task automatic do_reset();
    mem_if.mem_ren = 1'b0;
    mem_if.mem_wen = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", mem_if.mem_valid, 1'b0);
    check("rst_err",   mem_if.proto_err, 1'b0);
    check("rst_rdata", mem_if.mem_rdata, 32'h0);
    pend.delete();
    exp_err   = 1'b0;
    last_done = -100;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_ready", mem_if.mem_ready, 1'b1);
  endtask

  initial begin
    int v0, a1;
    bit acc;
    mem_if.mem_ren   = 1'b0;
    mem_if.mem_wen   = 1'b0;
    mem_if.mem_addr  = '0;
    mem_if.mem_wdata = '0;
    rst_n = 1'b0;
    #1;
    check("init_valid", mem_if.mem_valid, 1'b0);
    check("init_err",   mem_if.proto_err, 1'b0);
    check("init_rdata", mem_if.mem_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("init_ready", mem_if.mem_ready, 1'b1);

    // Preload words 0x000..0x0FC, the cache line at 0x100 and word 0x200.
    for (int unsigned i = 0; i < 64; i++) send(1'b0, 1'b1, i << 2, pre_val(i));
    for (int unsigned k = 0; k < 4; k++) send(1'b0, 1'b1, 32'h100 + (k << 2), 32'hA000_0000 + k);
    send(1'b0, 1'b1, 32'h200, 32'h0000_0200);
    drain();

    // Single read latency and data.
    v0 = n_valid;
    send(1'b1, 1'b0, 32'h10, '0);
    a1 = last_acc;
    drain();
    check("single_pulses", n_valid - v0, 1);
    check("single_latency", obs_valid_edge - a1, LATENCY + 1);
    check("single_rdata", obs_rdata, 32'hCAFE_F00D);

    // Cache line fill: ready drops once four are queued.
    v0 = n_valid;
    for (int unsigned k = 0; k < 4; k++) send(1'b1, 1'b0, 32'h100 + (k << 2), '0);
    check("line_full", mem_if.mem_ready, 1'b0);
    drain();
    check("line_pulses", n_valid - v0, 4);
    check("line_last", obs_rdata, 32'hA000_0003);

    // Write then read the same word back to back.
    v0 = n_valid;
    send(1'b0, 1'b1, 32'h200, 32'h1234_5678);
    send(1'b1, 1'b0, 32'h200, '0);
    drain();
    check("wr_rd_pulses", n_valid - v0, 1);
    check("wr_rd_data", obs_rdata, 32'h1234_5678);

    // Illegal request: dropped, error sticks, next read still works.
    v0 = n_valid;
    tick(1'b1, 1'b1, 32'h40, 32'hDEAD_DEAD, acc);
    check("illegal_err", mem_if.proto_err, 1'b1);
    repeat (8) idle();
    check("illegal_dropped", n_valid - v0, 0);
    send(1'b1, 1'b0, 32'h40, '0);
    drain();
    check("illegal_next_pulses", n_valid - v0, 1);
    check("illegal_next_data", obs_rdata, pre_val(32'h10));
    check("illegal_sticky", mem_if.proto_err, 1'b1);

    // Backpressure: fifth request waits for the first pop.
    v0 = n_valid;
    send(1'b1, 1'b0, 32'h100, '0);
    a1 = last_acc;
    for (int unsigned k = 1; k < 4; k++) send(1'b1, 1'b0, 32'h100 + (k << 2), '0);
    send(1'b1, 1'b0, 32'h24, '0);
    check("bp_accept_edge", last_acc - a1, LATENCY + 3);
    drain();
    check("bp_pulses", n_valid - v0, 5);
    check("bp_last", obs_rdata, pre_val(32'h09));

    // Reset while a write is waiting: write must be discarded.
    v0 = n_valid;
    send(1'b0, 1'b1, 32'h80, 32'hFFFF_FFFF);
    idle();
    idle();
    do_reset();
    send(1'b1, 1'b0, 32'h80, '0);
    drain();
    check("rst_pulses", n_valid - v0, 1);
    check("rst_mem_kept", obs_rdata, 32'h0BAD_BEEF);

    // Random traffic over the preloaded words with random upper address bits.
    for (int n = 0; n < 400; n++) begin
      int unsigned sel, idx;
      logic [31:0] addr;
      sel  = $urandom_range(0, 19);
      idx  = $urandom_range(0, 63);
      addr = ($urandom & 32'hFFFF_F000) | (idx << 2) | ($urandom & 32'h3);
      if (sel < 8)        tick(1'b1, 1'b0, addr, '0, acc);
      else if (sel < 14)  tick(1'b0, 1'b1, addr, $urandom, acc);
      else if (sel == 14) tick(1'b1, 1'b1, addr, $urandom, acc);
      else                idle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
